// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD message scheduler: frame geometry,
// the blank character, scheduler state encoding and a blank-frame builder.
package lcd_pkg;

    localparam int unsigned LCD_CHARS  = 32;
    localparam int unsigned CHAR_W     = 8;
    localparam int unsigned FRAME_W    = LCD_CHARS * CHAR_W;
    localparam logic [7:0]  BLANK_CHAR = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    function automatic logic [FRAME_W-1:0] blank_frame();
        return {LCD_CHARS{BLANK_CHAR}};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   i_req         - request vector, one bit per source
//   i_ptr         - index of the last served source
//   o_grant_valid - 1 when any request is set
//   o_grant_idx   - first requesting index after i_ptr, wrapping; i_ptr
//                   itself is considered last
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic                 o_grant_valid,
    output logic [$clog2(N)-1:0] o_grant_idx
);

    localparam int unsigned PW = $clog2(N);

    // Scan offsets from farthest to nearest so the nearest requester after
    // the pointer is the last assignment and therefore wins.
    always_comb begin : arb
        int unsigned cand;
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        cand          = 0;
        for (int unsigned k = N; k >= 1; k--) begin
            cand = (int'(i_ptr) + k) % N;
            if (i_req[cand]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/lcd_msg_scheduler.sv
// Shares one 16x2 character LCD between N_REQ message sources. Sources are
// granted round-robin; the winning frame is latched into a local buffer and
// held for at least HOLD_TICKS tick pulses before re-arbitration.
// Ports:
//   CLOCK_50   - system clock
//   Reset      - asynchronous active-high reset
//   tick       - one-cycle display-time strobe
//   req        - level request per source, held until ack
//   msg        - flattened frames, source i at [i*256 +: 256]
//   ack        - one-hot pulse in the cycle the source's frame is latched
//   characters - frame presented to the LCD driver, char 0 in [7:0]
//   busy       - a source owns the display (LOAD or SHOW)
//   owner      - index of current/last owner
//   hold_cnt_o - current hold count
module lcd_msg_scheduler
    import lcd_pkg::*;
#(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned HOLD_TICKS    = 2500,
    parameter bit          CLEAR_ON_IDLE = 1'b1
) (
    input  logic                     CLOCK_50,
    input  logic                     Reset,
    input  logic                     tick,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*FRAME_W-1:0] msg,
    output logic [N_REQ-1:0]         ack,
    output logic [FRAME_W-1:0]       characters,
    output logic                     busy,
    output logic [2:0]               owner,
    output logic [15:0]              hold_cnt_o
);

    localparam int unsigned PW       = $clog2(N_REQ);
    localparam logic [15:0] HOLD_MAX = 16'(HOLD_TICKS);
    localparam logic [PW-1:0] PTR_RST = PW'(N_REQ - 1);

    state_t             r_state, w_next_state;
    logic [PW-1:0]      r_ptr, r_winner, r_owner;
    logic [PW-1:0]      w_grant_idx;
    logic               w_grant_valid;
    logic               w_expired;
    logic [15:0]        r_hold;
    logic [FRAME_W-1:0] r_chars;
    logic [FRAME_W-1:0] w_frames [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_frames[g] = msg[g*FRAME_W +: FRAME_W];
    end

    rr_arbiter #(.N(N_REQ)) u_arb (
        .i_req         (req),
        .i_ptr         (r_ptr),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    assign w_expired = (r_hold == HOLD_MAX);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_grant_valid) w_next_state = ST_LOAD;
            ST_LOAD: w_next_state = ST_SHOW;
            ST_SHOW: begin
                if (w_expired) w_next_state = w_grant_valid ? ST_LOAD : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            r_ptr    <= PTR_RST;
            r_winner <= '0;
            r_owner  <= '0;
            r_hold   <= '0;
            r_chars  <= blank_frame();
        end else begin
            // LOAD is only ever entered from IDLE or an expired SHOW, so
            // capturing the arbiter result here registers the winner.
            if (w_next_state == ST_LOAD) r_winner <= w_grant_idx;
            case (r_state)
                ST_LOAD: begin
                    r_chars <= w_frames[r_winner];
                    r_owner <= r_winner;
                    r_ptr   <= r_winner;
                    r_hold  <= '0;
                end
                ST_SHOW: begin
                    if (!w_expired) begin
                        if (tick) r_hold <= r_hold + 16'd1;
                    end else if (!w_grant_valid && CLEAR_ON_IDLE) begin
                        r_chars <= blank_frame();
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ack = '0;
        if (r_state == ST_LOAD) ack[r_winner] = 1'b1;
    end

    assign busy       = (r_state != ST_IDLE);
    assign owner      = 3'(r_owner);
    assign characters = r_chars;
    assign hold_cnt_o = r_hold;

endmodule

// File: tb/tb_lcd_msg_scheduler.sv
module tb_lcd_msg_scheduler;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          tick = 1'b0;
    logic [3:0]    req  = '0;
    logic [1023:0] msg  = '0;

    logic [3:0]    ack0, ack1;
    logic [255:0]  chars0, chars1;
    logic          busy0, busy1;
    logic [2:0]    owner0, owner1;
    logic [15:0]   hold0, hold1;

    int checks   = 0;
    int failures = 0;

    logic [255:0] F [4];
    logic [255:0] G3;
    logic [255:0] BLANK;

    lcd_msg_scheduler #(.N_REQ(4), .HOLD_TICKS(4), .CLEAR_ON_IDLE(1'b1)) u_dut (
        .CLOCK_50(clk), .Reset(rst), .tick(tick), .req(req), .msg(msg),
        .ack(ack0), .characters(chars0), .busy(busy0), .owner(owner0),
        .hold_cnt_o(hold0)
    );

    lcd_msg_scheduler #(.N_REQ(4), .HOLD_TICKS(4), .CLEAR_ON_IDLE(1'b0)) u_dut_keep (
        .CLOCK_50(clk), .Reset(rst), .tick(tick), .req(req), .msg(msg),
        .ack(ack1), .characters(chars1), .busy(busy1), .owner(owner1),
        .hold_cnt_o(hold1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) F[i] = {32{8'h41 + 8'(i)}};
        G3    = {32{8'h5A}};
        BLANK = {32{8'h20}};
        for (int i = 0; i < 4; i++) msg[i*256 +: 256] = F[i];

        // Reset state
        rst = 1'b1;
        cyc(); cyc();
        chk("rst_chars", chars0, BLANK);
        chk("rst_busy", busy0, 0);
        chk("rst_ack", ack0, 0);
        chk("rst_owner", owner0, 0);
        chk("rst_hold", hold0, 0);
        rst = 1'b0;
        cyc();
        chk("idle_busy", busy0, 0);
        chk("idle_chars", chars0, BLANK);

        // Single request from source 2; tick during LOAD is ignored
        req = 4'b0100;
        cyc();
        chk("single_ack", ack0, 4'b0100);
        chk("single_busy_load", busy0, 1);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("single_ack_off", ack0, 0);
        chk("single_chars", chars0, F[2]);
        chk("single_owner", owner0, 2);
        chk("load_tick_ignored", hold0, 0);
        req = 4'b0000;
        for (int i = 1; i <= 4; i++) begin
            do_tick();
            chk("single_hold", hold0, i);
            chk("single_busy_show", busy0, 1);
        end
        cyc();
        chk("single_idle_busy", busy0, 0);
        chk("single_idle_blank", chars0, BLANK);
        chk("keep_idle_busy", busy1, 0);
        chk("keep_idle_chars", chars1, F[2]);

        // Round-robin with all sources requesting; fresh pointer after reset
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req = 4'b1111;
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("rr_ack", ack0, 4'b0001 << (k % 4));
            cyc();
            chk("rr_chars", chars0, F[k % 4]);
            chk("rr_owner", owner0, k % 4);
            for (int t = 0; t < 4; t++) begin
                do_tick();
                chk("rr_hold_ack", ack0, 0);
                chk("rr_hold_chars", chars0, F[k % 4]);
            end
            cyc();
        end
        // Now in LOAD for source 1; take it to SHOW, then reset asynchronously
        req = 4'b0000;
        cyc();
        chk("rr_tail_chars", chars0, F[1]);
        do_tick();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_chars", chars0, BLANK);
        chk("async_rst_busy", busy0, 0);
        chk("async_rst_ack", ack0, 0);
        chk("async_rst_owner", owner0, 0);
        chk("async_rst_hold", hold0, 0);
        cyc();
        rst = 1'b0;

        // Non-preemption: source 0 asks while source 1 is showing
        req = 4'b0010;
        cyc();
        chk("np_ack1", ack0, 4'b0010);
        cyc();
        chk("np_chars1", chars0, F[1]);
        do_tick();
        req = 4'b0011;
        for (int t = 0; t < 3; t++) begin
            do_tick();
            chk("np_hold_chars", chars0, F[1]);
            chk("np_no_ack", ack0, 0);
        end
        cyc();
        chk("np_ack0", ack0, 4'b0001);
        req = 4'b0000;
        cyc();
        chk("np_chars0", chars0, F[0]);
        chk("np_owner0", owner0, 0);
        for (int t = 0; t < 4; t++) do_tick();
        cyc();
        chk("np_idle_busy", busy0, 0);

        // Re-win by a lone requester, frame frozen during SHOW
        req = 4'b1000;
        cyc();
        chk("rw_ack_a", ack0, 4'b1000);
        cyc();
        chk("rw_chars_a", chars0, F[3]);
        do_tick();
        msg[3*256 +: 256] = G3;
        for (int t = 0; t < 3; t++) begin
            do_tick();
            chk("rw_frozen", chars0, F[3]);
        end
        cyc();
        chk("rw_ack_b", ack0, 4'b1000);
        chk("rw_still_old", chars0, F[3]);
        cyc();
        chk("rw_chars_b", chars0, G3);
        chk("keep_rw_chars_b", chars1, G3);
        req = 4'b0000;
        for (int t = 0; t < 4; t++) do_tick();
        cyc();
        chk("rw_idle_blank", chars0, BLANK);
        chk("keep_rw_busy", busy1, 0);
        chk("keep_rw_chars", chars1, G3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_msg_scheduler.md
Name: lcd_msg_scheduler

Overview:
Shares the single 16x2 character LCD between N_REQ message sources, for example the game narrative, the status line and error banners. Each source raises a request with a full 32-character frame. The scheduler grants sources round-robin, latches the winning frame into its own buffer, and holds it on screen for a minimum number of display ticks. Its `characters` output drives the 256-bit character bus of the LCD driver directly, with character 0 in bits [7:0].

Parameters:
N_REQ, 4, number of requesters (2..8)
HOLD_TICKS, 2500, minimum display time, counted in `tick` pulses (>=1)
CLEAR_ON_IDLE, 1, 1 = frame buffer reverts to all-blank when no source owns the display

Ports:
CLOCK_50  in  1  system clock
Reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle display-time strobe (e.g. the LCD driver's CLK_2500 pulse)
req  in  N_REQ  level request per source; held until ack
msg  in  N_REQ*256  flattened frames; source i occupies [i*256 +: 256]
ack  out  N_REQ  one-hot, one-cycle pulse: frame of source i latched this cycle
characters  out  256  frame presented to the LCD driver
busy  out  1  1 while a source owns the display (LOAD or SHOW)
owner  out  3  index of current/last owner (valid when busy)
hold_cnt_o  out  16  current hold count, debug/verification visibility

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state=IDLE; characters=32 x 8'h20; ack=0; busy=0; owner=0; hold counter=0.
  - RR pointer = N_REQ-1, so source 0 wins the first arbitration.
- States: IDLE, LOAD, SHOW.
- IDLE:
  - If any req bit is set, go to LOAD next cycle. The winner is computed combinationally from req and the RR pointer and registered.
  - Otherwise stay in IDLE.
- LOAD (exactly 1 cycle):
  - characters <= msg slice of the winner.
  - ack[winner] pulses high for this cycle only.
  - owner <= winner; RR pointer <= winner; hold counter <= 0; busy=1.
  - Next state is SHOW.
- SHOW:
  - Hold counter increments on each cycle with tick=1, saturating at HOLD_TICKS.
  - characters stay constant; later msg changes from the owner are not reflected.
- SHOW expiry (counter == HOLD_TICKS, evaluated each cycle):
  - Any req bit set: go to LOAD with a new RR winner, searched from pointer+1 upward with wrap. The current owner is considered last, so it re-wins only when no other source is requesting. A re-win re-latches its frame and pulses ack again.
  - No req: go to IDLE. If CLEAR_ON_IDLE=1, characters <= blank in the same transition; otherwise the last frame remains.
- Requests arriving during SHOW before expiry are queued implicitly, since req is level. They never preempt the current owner.
- A source dropping req before its ack simply withdraws; there is no error.
- A tick coinciding with the LOAD cycle is ignored; ticks are counted only in SHOW.
- The whole frame updates in one cycle, so the LCD driver never sees a partially written frame. A frame may change mid-refresh of the LCD, which is acceptable: the next refresh pass shows it fully.
- Reset asserted mid-SHOW discards the current owner and pending order.
- HOLD_TICKS is held in a 16-bit counter; values above 65535 are illegal.
- Worst-case wait for any requesting source: (N_REQ-1) x (HOLD_TICKS+1) ticks plus N_REQ LOAD cycles.

Decomposition:
- Shared package lcd_pkg:
  - LCD_CHARS=32, CHAR_W=8, FRAME_W=256, BLANK_CHAR=8'h20.
  - State encoding for IDLE/LOAD/SHOW.
  - A function building a blank frame.
- Sub-module rr_arbiter (parameter N): combinational. Inputs are req[N] and ptr; outputs are grant_valid and grant_idx, the first set bit after ptr with wrap. This is reusable by other shared-resource blocks.

Test Plan:
- Reset, then idle: characters == 256'h2020...20, busy=0, ack=0. Assert Reset mid-SHOW: same values within the same cycle, asynchronously.
- Single request, with HOLD_TICKS=4: req=4'b0100, msg[2]="ROOM 1..." → ack=4'b0100 exactly one cycle, owner=2, characters equal msg[2]. Drop req and give 4 ticks → IDLE, characters blank.
- Round-robin fairness: hold req=4'b1111 for 20 tick periods. Ack order is 0,1,2,3,0; each frame is shown for exactly 4 ticks, and no source is granted twice before the others are served.
- Non-preemption: source 1 is showing, source 0 requests after 1 tick. characters stay msg[1] until the 4th tick, then source 0 is loaded.
- Re-win and freeze: only source 3 requests, continuously. ack[3] pulses every 4 ticks plus the LOAD cycle. Changing msg[3] mid-SHOW does not alter characters until the next ack.
- CLEAR_ON_IDLE=0 variant: after the owner releases, characters retain the last frame while busy=0.
